// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset vector, instruction width
// and the sequential PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with synchronous reset, parallel load and
// increment by one instruction. The load has priority over the increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        inc,
  output logic [31:0] pc
);

  // PC update: reset vector, redirect target, or next sequential word
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory,
// buffers one instruction for the decoder and handles redirects. DRAIN lets
// a request that was abandoned by a redirect finish on its original address.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_t           state;
  fetch_state_t           next_state;
  logic [31:0]            pc;
  logic [31:0]            target;
  logic [31:0]            drain_addr;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [31:0]            instr_pc_q;
  logic                   pc_load;
  logic                   pc_inc;
  logic                   buf_load;
  logic                   drain_load;

  assign target    = redirect_target & ~32'h0000_0003;
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Next state, request/valid outputs and datapath enables; redirect wins
  always_comb begin
    next_state  = state;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    buf_load    = 1'b0;
    drain_load  = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (redirect_valid) begin
            pc_load    = 1'b1;
            drain_load = ~imem_ack;
            next_state = imem_ack ? FETCH : DRAIN;
          end else if (imem_ack) begin
            buf_load   = 1'b1;
            pc_inc     = 1'b1;
            next_state = HOLD;
          end
        end
        HOLD: begin
          instr_valid = ~redirect_valid;
          if (redirect_valid) begin
            pc_load    = 1'b1;
            next_state = FETCH;
          end else if (instr_ready) begin
            imem_req = 1'b1;
            if (imem_ack) begin
              buf_load = 1'b1;
              pc_inc   = 1'b1;
            end else begin
              next_state = FETCH;
            end
          end
        end
        DRAIN: begin
          imem_req = 1'b1;
          pc_load  = redirect_valid;
          if (imem_ack) begin
            next_state = FETCH;
          end
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

  // State register, instruction buffer and the held address of a draining request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      drain_addr <= '0;
    end else begin
      state <= next_state;
      if (buf_load) begin
        instr_q    <= imem_data;
        instr_pc_q <= pc;
      end
      if (drain_load) begin
        drain_addr <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table for streaming, redirect
// and wrap-around, then hand-written stall, drain and reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic ack_en;
  logic ack_force;
  int   checks;
  int   errors;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] eipc;
  } vec_t;

  vec_t vecs[12];

  // Memory model: every word holds the inverse of its address
  assign imem_ack  = ack_force | (imem_req & ack_en);
  assign imem_data = ~imem_addr;

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a, input logic rdy,
                               input logic rv, input logic [31:0] rt);
    rst             = r;
    ack_en          = a;
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ereq, input logic [31:0] eaddr,
                             input logic evalid, input logic [31:0] eipc);
    checkVal({name, ".req"}, {31'd0, imem_req}, {31'd0, ereq});
    if (ereq) checkVal({name, ".addr"}, imem_addr, eaddr);
    checkVal({name, ".valid"}, {31'd0, instr_valid}, {31'd0, evalid});
    if (evalid) begin
      checkVal({name, ".instr_pc"}, instr_pc, eipc);
      checkVal({name, ".instr"}, instr, ~eipc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runStep(input string name, input logic r, input logic a, input logic rdy,
                         input logic rv, input logic [31:0] rt, input logic ereq,
                         input logic [31:0] eaddr, input logic evalid, input logic [31:0] eipc);
    applyStimulus(r, a, rdy, rv, rt);
    checkOutput(name, ereq, eaddr, evalid, eipc);
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ack_force = 1'b0;
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h203,       1'b0, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h204,       1'b1, 32'h200};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0};

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkVal("reset.instr", instr, 32'h0);
    checkVal("reset.instr_pc", instr_pc, 32'h0);

    for (int i = 0; i < 12; i++) begin
      runStep($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ack, vecs[i].rdy, vecs[i].rv,
              vecs[i].rt, vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].eipc);
    end

    for (int i = 0; i < 3; i++) begin
      runStep($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    end
    runStep("release",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0);
    runStep("hold_noack", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h4);

    runStep("fetch_redir", 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h8,   1'b0, 32'h0);
    runStep("drain_wait",  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    runStep("drain_ack",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0);
    runStep("fetch_100",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
    runStep("hold_100",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100);

    runStep("hold_noack2", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);
    runStep("redir_300",   1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h104, 1'b0, 32'h0);
    runStep("redir_400",   1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h104, 1'b0, 32'h0);
    runStep("drain_ack2",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    runStep("redir_500",   1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400, 1'b0, 32'h0);

    ack_force = 1'b1;
    runStep("rst_in_drain", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    ack_force = 1'b0;
    runStep("post_rst",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    runStep("post_rst_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
